conv_mem_host: RTL and testbench
================================

# conv_mem_host

Host-side memory responder for the 3x3 convolution engine. It holds the 64x64 input image and the two layer memories (L0 4096 words, L1 1024 words). It answers the engine's image-read, layer-read and layer-write requests with the timing the engine expects. It loads the image from an input stream, starts the engine with a `ready` pulse, and streams the L1 result out after the engine drops `busy`.

## Interface
- `DW`, 13: data word width (signed image pixels, unsigned layer data).
- `AW`, 12: image/L0 address width (4096 words; address = {row[11:6], col[5:0]}).
- `L1_WORDS`, 1024: L1 depth; only `caddr_wr[9:0]` and `caddr_rd[9:0]` are used when `csel`=1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: reset is synchronous and active-low; `reset`=0 at a rising edge resets the block.
- `in_valid` in 1: image stream word valid.
- `in_data` in DW: image pixel, raster order, row-major.
- `in_ready` out 1: image stream accept; a word transfers when `in_valid`&&`in_ready`.
- `ready` out 1: engine start pulse.
- `busy` in 1: engine busy.
- `iaddr` in AW: engine image read address.
- `idata` out DW: image read data.
- `cwr` in 1: layer write enable.
- `caddr_wr` in AW: layer write address.
- `cdata_wr` in DW: layer write data.
- `crd` in 1: layer read enable.
- `caddr_rd` in AW: layer read address.
- `cdata_rd` out DW: layer read data.
- `csel` in 1: bank select; 0=L0, 1=L1.
- `out_valid` out 1: L1 dump word valid.
- `out_data` out DW: L1 word.
- `out_ready` in 1: dump accept.
- `done` out 1: dump complete, sticky until reset.
- `err` out 1: sticky protocol error.

## Operation
- FSM states: LOAD, START, RUN, DUMP, DONE. Reset state is LOAD.
- **LOAD**
  - `in_ready`=1.
  - Each accepted word is written to `img[load_cnt]`, and `load_cnt` increments.
  - When word 4095 is accepted, go to START.
- **START**
  - `ready`=1 for exactly one cycle, then go to RUN.
  - Clear `seen_busy`.
- **RUN**
  - Set `seen_busy` when `busy`=1.
  - When `seen_busy`=1 and `busy`=0, go to DUMP with `dump_cnt`=0.
- **Image read**: `idata` = `img[iaddr]`, combinational, valid in every state.
- **Layer read**: `cdata_rd` = `csel` ? `L1[caddr_rd[9:0]]` : `L0[caddr_rd]` when `crd`=1; otherwise 0. Combinational.
- **Layer write**
  - When `cwr`=1 in RUN, write `cdata_wr` at the clock edge to `L1[caddr_wr[9:0]]` if `csel`=1, else to `L0[caddr_wr]`.
  - A read of the same address in the same cycle returns the old data.
- **DUMP**
  - `out_valid`=1 and `out_data` = `L1[dump_cnt]`.
  - On `out_valid`&&`out_ready`, `dump_cnt` increments.
  - Transfer of word 1023 goes to DONE.
  - `out_data` is stable while stalled.
- **DONE**: `done`=1; all other outputs idle; the FSM stays in DONE until reset.
- **`err` set conditions** (sticky):
  - `cwr`=1 outside RUN (write ignored);
  - `cwr`=1 with `csel`=1 and `caddr_wr[11:10]`!=0 (write ignored);
  - `cwr`&&`crd` in the same cycle (write still performed);
  - `in_valid`=1 outside LOAD (word dropped).
- **Reset** (`reset`=0, any state, including mid-load or mid-dump):
  - state becomes LOAD; `load_cnt`, `dump_cnt`, `seen_busy`, `done`, `err`, `ready` and `out_valid` are cleared;
  - memory contents are not cleared.

## Timing
- Output values in the first cycle after reset: `in_ready`=1, `ready`=0, `out_valid`=0, `done`=0, `err`=0, `cdata_rd`=0 if `crd`=0.
- `idata` and `cdata_rd` have zero-cycle latency. The engine registers the address at edge k and samples the data at edge k+1.
- `ready` rises in the cycle after the 4096th image word is accepted and lasts exactly 1 cycle.
- DUMP is entered 1 cycle after `busy` is sampled low (with `seen_busy`=1).
- `out_valid` is first asserted in that DUMP cycle.
- With `out_ready` held at 1, the dump takes 1024 cycles, one word per cycle. `done` rises in the following cycle.
- A `busy` that never rises keeps the block in RUN indefinitely. There is no timeout.

## Test plan
- **Load/start**: stream pixels `img[i]`=i mod 8192 with `in_valid`=1 throughout.
  - Required: `in_ready` is 1 for 4096 cycles.
  - Required: `ready` pulses 1 cycle later; `idata` for `iaddr`=12'h041 reads 13'h0041.
- **Backpressure-free read/write**:
  - In RUN, `cwr`=1, `csel`=0, `caddr_wr`=5, `cdata_wr`=13'h0123; the next cycle `crd`=1, `caddr_rd`=5 → `cdata_rd`=13'h0123.
  - With `crd`=0 → `cdata_rd`=0.
- **Bank separation**:
  - Write L1[3]=13'h00F0 (`csel`=1).
  - Required: L0[3] read with `csel`=0 is unchanged.
  - Required: a `csel`=1 write to `caddr_wr`=1030 sets `err` and leaves L1[6] unchanged.
- **Dump with stalls**:
  - Fill L1[k]=k. `busy` goes 1→0 in RUN. Toggle `out_ready` 1,0,0,1…
  - Required: 1024 words 0..1023 in order, none repeated or skipped, `out_data` stable during stalls, then `done`=1.
- **Protocol errors**:
  - `in_valid`=1 during RUN → `err`=1, image unchanged.
  - `cwr`=1 during LOAD → `err`=1, no layer write.
- **Reset mid-operation**:
  - Assert `reset`=0 after 2000 image words, release, and stream 4096 new words.
  - Required: `ready` fires exactly once, after the new 4096th word; `done`/`err` are 0 after reset.

Source files
------------

// File: rtl/conv_mem_host.sv
`default_nettype none
// ============================================================================
// Module   : conv_mem_host
// Purpose  : Host-side memory responder for the 3x3 convolution engine.
//            Holds the 64x64 input image plus the L0 (4096-word) and
//            L1 (1024-word) layer memories. Loads the image from a
//            valid/ready stream, pulses `ready` to start the engine, serves
//            the engine's combinational image/layer reads and clocked layer
//            writes, then streams L1 out once the engine drops `busy`.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   single clock, rising edge
//   reset      in   synchronous, active-low
//   in_valid   in   image stream word valid
//   in_data    in   image pixel (raster order)
//   in_ready   out  image stream accept (high in LOAD)
//   ready      out  one-cycle engine start pulse
//   busy       in   engine busy
//   iaddr      in   image read address {row, col}
//   idata      out  image read data (zero latency)
//   cwr        in   layer write enable
//   caddr_wr   in   layer write address
//   cdata_wr   in   layer write data
//   crd        in   layer read enable
//   caddr_rd   in   layer read address
//   cdata_rd   out  layer read data (zero latency, 0 when crd=0)
//   csel       in   bank select, 0=L0 1=L1
//   out_valid  out  L1 dump word valid
//   out_data   out  L1 dump word
//   out_ready  in   dump accept
//   done       out  dump complete (sticky until reset)
//   err        out  sticky protocol error
// ============================================================================
module conv_mem_host #(
    parameter int DW       = 13,
    parameter int AW       = 12,
    parameter int L1_WORDS = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic          csel,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          done,
    output logic          err
);

    localparam int              IMG_WORDS   = 1 << AW;
    localparam int              L1AW        = $clog2(L1_WORDS);
    localparam logic [AW-1:0]   c_load_last = AW'(IMG_WORDS - 1);
    localparam logic [AW-1:0]   c_load_one  = AW'(1);
    localparam logic [L1AW-1:0] c_dump_last = L1AW'(L1_WORDS - 1);
    localparam logic [L1AW-1:0] c_dump_one  = L1AW'(1);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DUMP  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [AW-1:0]     r_load_cnt;
    logic [L1AW-1:0]   r_dump_cnt;
    logic              r_seen_busy;
    logic              r_err;

    logic [DW-1:0]     r_img [IMG_WORDS];
    logic [DW-1:0]     r_l0  [IMG_WORDS];
    logic [DW-1:0]     r_l1  [L1_WORDS];

    logic              w_load_fire;
    logic              w_dump_fire;
    logic              w_l1_oob;
    logic              w_wr_en;
    logic              w_err_set;

    assign w_load_fire = (r_state == S_LOAD) && in_valid;
    assign w_dump_fire = (r_state == S_DUMP) && out_ready;
    // An L1 write whose address has bits set above the L1 depth is rejected.
    assign w_l1_oob    = csel && (caddr_wr[AW-1:L1AW] != '0);
    assign w_wr_en     = cwr && (r_state == S_RUN) && !w_l1_oob;
    assign w_err_set   = (cwr && (r_state != S_RUN))
                       || (cwr && w_l1_oob)
                       || (cwr && crd)
                       || (in_valid && (r_state != S_LOAD));

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_LOAD:  if (w_load_fire && (r_load_cnt == c_load_last)) w_state_nx = S_START;
            S_START: w_state_nx = S_RUN;
            S_RUN:   if (r_seen_busy && !busy) w_state_nx = S_DUMP;
            S_DUMP:  if (w_dump_fire && (r_dump_cnt == c_dump_last)) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_DONE;
            default: w_state_nx = S_LOAD;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_load_cnt  <= '0;
            r_dump_cnt  <= '0;
            r_seen_busy <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_load_fire)
                r_load_cnt <= r_load_cnt + c_load_one;
            if (r_state == S_START)
                r_seen_busy <= 1'b0;
            else if ((r_state == S_RUN) && busy)
                r_seen_busy <= 1'b1;
            if ((r_state == S_RUN) && (w_state_nx == S_DUMP))
                r_dump_cnt <= '0;
            else if (w_dump_fire)
                r_dump_cnt <= r_dump_cnt + c_dump_one;
            if (w_err_set)
                r_err <= 1'b1;
        end
    end

    // Memories keep their contents across reset; writes are held off only
    // while reset is asserted.
    always_ff @(posedge clk) begin
        if (reset && w_load_fire)
            r_img[r_load_cnt] <= in_data;
        if (reset && w_wr_en) begin
            if (csel)
                r_l1[caddr_wr[L1AW-1:0]] <= cdata_wr;
            else
                r_l0[caddr_wr] <= cdata_wr;
        end
    end

    // Zero-latency read paths; a same-cycle write lands at the edge, so the
    // read returns the old word.
    assign idata    = r_img[iaddr];
    assign cdata_rd = !crd ? '0 : (csel ? r_l1[caddr_rd[L1AW-1:0]] : r_l0[caddr_rd]);

    assign in_ready  = (r_state == S_LOAD);
    assign ready     = (r_state == S_START);
    assign out_valid = (r_state == S_DUMP);
    assign out_data  = (r_state == S_DUMP) ? r_l1[r_dump_cnt] : '0;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_mem_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mem_host
// Purpose  : Directed self-checking bench for conv_mem_host: image load and
//            start pulse, layer read/write, bank separation, stalled L1 dump,
//            protocol errors and reset in the middle of a load.
// Revision : 1.0  initial release
// ============================================================================
module tb_conv_mem_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [12:0] in_data;
    logic        in_ready;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [12:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [12:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [12:0] cdata_rd;
    logic        csel;
    logic        out_valid;
    logic [12:0] out_data;
    logic        out_ready;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    conv_mem_host #(.DW(13), .AW(12), .L1_WORDS(1024)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .ready     (ready),
        .busy      (busy),
        .iaddr     (iaddr),
        .idata     (idata),
        .cwr       (cwr),
        .caddr_wr  (caddr_wr),
        .cdata_wr  (cdata_wr),
        .crd       (crd),
        .caddr_rd  (caddr_rd),
        .cdata_rd  (cdata_rd),
        .csel      (csel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams n words; rev selects value 4095-i instead of i.
    task automatic load_words(input int n, input bit rev);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = rev ? 13'(4095 - i) : 13'(i);
            #2;
            check("load_in_ready", {31'd0, in_ready}, 32'd1);
            check("load_ready_low", {31'd0, ready}, 32'd0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        int exp_w;
        int cyc;
        reset = 1'b0; in_valid = 1'b0; in_data = '0; busy = 1'b0; iaddr = '0;
        cwr = 1'b0; caddr_wr = '0; cdata_wr = '0; crd = 1'b0; caddr_rd = '0;
        csel = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #2;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_ready",     {31'd0, ready},     32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_done",      {31'd0, done},      32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        check("rst_cdata_rd",  {19'd0, cdata_rd},  32'd0);

        // ---- load and start ----
        tick();
        load_words(4096, 1'b0);
        #2;
        check("start_ready",    {31'd0, ready},    32'd1);
        check("start_in_ready", {31'd0, in_ready}, 32'd0);
        iaddr = 12'h041;
        #1;
        check("idata_041", {19'd0, idata}, 32'h0041);
        tick();
        #2;
        check("ready_one_cycle", {31'd0, ready}, 32'd0);

        // ---- RUN: L0 write then read ----
        cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd5; cdata_wr = 13'h0123; crd = 1'b0;
        #2;
        check("crd0_zero", {19'd0, cdata_rd}, 32'd0);
        tick();
        cwr = 1'b0; crd = 1'b1; caddr_rd = 12'd5;
        #2;
        check("l0_rd5", {19'd0, cdata_rd}, 32'h0123);
        check("err_clean", {31'd0, err}, 32'd0);
        crd = 1'b0;

        // ---- bank separation ----
        cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd3; cdata_wr = 13'h0AAA;
        tick();
        csel = 1'b1; cdata_wr = 13'h00F0;
        tick();
        cwr = 1'b0; crd = 1'b1; csel = 1'b0; caddr_rd = 12'd3;
        #2;
        check("l0_3_kept", {19'd0, cdata_rd}, 32'h0AAA);
        csel = 1'b1;
        #2;
        check("l1_3", {19'd0, cdata_rd}, 32'h00F0);
        crd = 1'b0;

        // ---- fill L1[k]=k ----
        for (int k = 0; k < 1024; k++) begin
            cwr = 1'b1; csel = 1'b1; caddr_wr = 12'(k); cdata_wr = 13'(k);
            tick();
        end
        cwr = 1'b0; crd = 1'b1; csel = 1'b1; caddr_rd = 12'd6;
        #2;
        check("l1_6", {19'd0, cdata_rd}, 32'd6);
        check("err_still_clean", {31'd0, err}, 32'd0);
        crd = 1'b0;
        cwr = 1'b1; csel = 1'b1; caddr_wr = 12'd1030; cdata_wr = 13'h1FFF;
        tick();
        cwr = 1'b0;
        #2;
        check("err_l1_oob", {31'd0, err}, 32'd1);
        crd = 1'b1; caddr_rd = 12'd6;
        #2;
        check("l1_6_unchanged", {19'd0, cdata_rd}, 32'd6);
        crd = 1'b0;

        // ---- busy 1 -> 0, stalled dump ----
        busy = 1'b1;
        tick();
        busy = 1'b0;
        #2;
        check("no_dump_yet", {31'd0, out_valid}, 32'd0);
        tick();
        exp_w = 0;
        cyc   = 0;
        while (exp_w < 1024 && cyc < 5000) begin
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            #2;
            check("dump_valid", {31'd0, out_valid}, 32'd1);
            check("dump_data", {19'd0, out_data}, 32'(exp_w));
            tick();
            if (out_ready) exp_w++;
            cyc++;
        end
        out_ready = 1'b0;
        #2;
        check("dump_count", 32'(exp_w), 32'd1024);
        check("done_set", {31'd0, done}, 32'd1);
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        #2;
        check("done_sticky", {31'd0, done}, 32'd1);

        // ---- reset, then cwr during LOAD ----
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check("rst2_done", {31'd0, done}, 32'd0);
        check("rst2_err", {31'd0, err}, 32'd0);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        cwr = 1'b1; csel = 1'b0; caddr_wr = 12'd5; cdata_wr = 13'h0777;
        tick();
        cwr = 1'b0;
        #2;
        check("err_cwr_load", {31'd0, err}, 32'd1);
        crd = 1'b1; csel = 1'b0; caddr_rd = 12'd5;
        #2;
        check("l0_5_no_write", {19'd0, cdata_rd}, 32'h0123);
        crd = 1'b0;

        // ---- reset mid-load ----
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        load_words(2000, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check("rst3_err", {31'd0, err}, 32'd0);
        check("rst3_ready", {31'd0, ready}, 32'd0);
        tick();
        load_words(4096, 1'b1);
        #2;
        check("reload_ready", {31'd0, ready}, 32'd1);
        tick();
        #2;
        check("reload_ready_once", {31'd0, ready}, 32'd0);
        iaddr = 12'h041;
        #1;
        check("reload_idata_041", {19'd0, idata}, 32'h0FBE);

        // ---- in_valid during RUN ----
        in_valid = 1'b1; in_data = 13'h1ABC;
        tick();
        in_valid = 1'b0;
        #2;
        check("err_in_valid_run", {31'd0, err}, 32'd1);
        iaddr = 12'h000;
        #1;
        check("img0_unchanged", {19'd0, idata}, 32'h0FFF);
        iaddr = 12'h041;
        #1;
        check("img41_unchanged", {19'd0, idata}, 32'h0FBE);
        check("ready_stays_low", {31'd0, ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
